// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-port arbiter.
package axi_rd_pkg;

  localparam int unsigned AXI_LEN_W      = 8;
  localparam logic [1:0]  AXI_BURST_INCR = 2'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/axi_read_arbiter_picker.sv
// Winner selection: port 0 has strict priority, ports 1..NUM_PORTS-1 rotate
// starting after rr_last.
//   req         : per-port request vector
//   rr_last     : last round-robin port granted (1..NUM_PORTS-1)
//   win_idx_c   : winning port index (valid only with win_valid_c)
//   win_valid_c : at least one request present
module rr_priority_picker #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_last,
  output logic [IDX_W-1:0]     win_idx_c,
  output logic                 win_valid_c
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_idx_c   = '0;
    win_valid_c = 1'b0;
    cand        = '0;
    if (req[0]) begin
      win_valid_c = 1'b1;
    end else begin
      // Walk the rotation 1..NUM_PORTS-1 beginning just after rr_last.
      for (int unsigned k = 1; k < NUM_PORTS; k++) begin
        cand = IDX_W'(((32'(rr_last) + k - 1) % (NUM_PORTS - 1)) + 1);
        if (!win_valid_c && req[cand]) begin
          win_idx_c   = cand;
          win_valid_c = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI4 read port (AR + R, no IDs) between NUM_PORTS masters.
// Port 0 has strict priority, the rest are round-robin; one burst in flight,
// grant held from AR acceptance until the R beat with last. Each burst's
// beat count is checked against its requested length.
//   clk, reset          : clock, synchronous active-high reset
//   s_ar_* / s_r_*      : upstream per-port AR and R channels
//   m_ar_* / m_r_*      : downstream shared AR and R channels
//   grant               : current owning port (registered)
//   busy                : burst in ADDR or DATA (registered)
//   len_err             : one-cycle pulse on burst length mismatch (registered)
module axi_read_arbiter
  import axi_rd_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           s_ar_valid,
  output logic [NUM_PORTS-1:0]           s_ar_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0]    s_ar_addr,
  input  logic [NUM_PORTS*8-1:0]         s_ar_len,
  input  logic [NUM_PORTS*2-1:0]         s_ar_burst,
  output logic [NUM_PORTS-1:0]           s_r_valid,
  input  logic [NUM_PORTS-1:0]           s_r_ready,
  output logic [DATA_W-1:0]              s_r_data,
  output logic                           s_r_last,
  output logic                           m_ar_valid,
  input  logic                           m_ar_ready,
  output logic [ADDR_W-1:0]              m_ar_addr,
  output logic [7:0]                     m_ar_len,
  output logic [1:0]                     m_ar_burst,
  input  logic                           m_r_valid,
  output logic                           m_r_ready,
  input  logic [DATA_W-1:0]              m_r_data,
  input  logic                           m_r_last,
  output logic [$clog2(NUM_PORTS)-1:0]   grant,
  output logic                           busy,
  output logic                           len_err
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  arb_state_t           state, state_nxt;
  logic [IDX_W-1:0]     grant_nxt, rr_last, rr_last_nxt;
  logic [AXI_LEN_W-1:0] exp_len, exp_len_nxt, beat_cnt, beat_cnt_nxt;
  logic                 busy_nxt, len_err_nxt;
  logic [IDX_W-1:0]     win_idx_c;
  logic                 win_valid_c;

  rr_priority_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req         (s_ar_valid),
    .rr_last     (rr_last),
    .win_idx_c   (win_idx_c),
    .win_valid_c (win_valid_c)
  );

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_last  <= IDX_W'(NUM_PORTS - 1);
      exp_len  <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_last  <= rr_last_nxt;
      exp_len  <= exp_len_nxt;
      beat_cnt <= beat_cnt_nxt;
      busy     <= busy_nxt;
      len_err  <= len_err_nxt;
    end
  end

  // Next-state logic and channel routing.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_last_nxt  = rr_last;
    exp_len_nxt  = exp_len;
    beat_cnt_nxt = beat_cnt;
    len_err_nxt  = 1'b0;
    s_ar_ready   = '0;
    m_ar_valid   = 1'b0;
    m_ar_addr    = '0;
    m_ar_len     = '0;
    m_ar_burst   = '0;
    s_r_valid    = '0;
    m_r_ready    = 1'b0;
    s_r_data     = '0;
    s_r_last     = 1'b0;

    case (state)
      IDLE: begin
        if (win_valid_c) begin
          grant_nxt   = win_idx_c;
          exp_len_nxt = s_ar_len[32'(win_idx_c)*AXI_LEN_W +: AXI_LEN_W];
          // Port 0 sits outside the rotation and leaves it untouched.
          if (win_idx_c != '0) rr_last_nxt = win_idx_c;
          state_nxt   = ADDR;
        end
      end

      ADDR: begin
        m_ar_valid        = s_ar_valid[grant];
        m_ar_addr         = s_ar_addr[32'(grant)*ADDR_W +: ADDR_W];
        m_ar_len          = s_ar_len[32'(grant)*AXI_LEN_W +: AXI_LEN_W];
        m_ar_burst        = s_ar_burst[32'(grant)*2 +: 2];
        s_ar_ready[grant] = m_ar_ready;
        if (m_ar_valid && m_ar_ready) begin
          beat_cnt_nxt = '0;
          state_nxt    = DATA;
        end
      end

      DATA: begin
        s_r_valid[grant] = m_r_valid;
        m_r_ready        = s_r_ready[grant];
        s_r_data         = m_r_data;
        s_r_last         = m_r_last;
        if (m_r_valid && m_r_ready) begin
          // beat_cnt is the zero-based index of the beat being accepted.
          if (beat_cnt != '1) beat_cnt_nxt = beat_cnt + AXI_LEN_W'(1);
          if (m_r_last) begin
            len_err_nxt = (beat_cnt != exp_len);
            state_nxt   = IDLE;
          end else if (beat_cnt == exp_len) begin
            // Burst overran its length; keep routing until last arrives.
            len_err_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
